// File: rtl/sinkd_resp_sched.sv
// D-channel response buffer for the L2: an in-order FIFO steered by opcode to the refill or
// write-ack consumer, plus a credit counter that bounds outstanding A-channel requests.
module sinkd_resp_sched #(
  parameter int DEPTH  = 4,
  parameter int OP_W   = 3,
  parameter int SRC_W  = 8,
  parameter int DATA_W = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid_i,
  input  logic [OP_W-1:0]            in_opcode_i,
  input  logic [SRC_W-1:0]           in_source_i,
  input  logic [DATA_W-1:0]          in_data_i,
  input  logic                       a_fire_i,
  output logic                       credit_avail_o,
  output logic [$clog2(DEPTH):0]     credits_o,
  output logic                       refill_valid_o,
  input  logic                       refill_ready_i,
  output logic [SRC_W-1:0]           refill_source_o,
  output logic [DATA_W-1:0]          refill_data_o,
  output logic                       wack_valid_o,
  input  logic                       wack_ready_i,
  output logic [OP_W-1:0]            wack_opcode_o,
  output logic [SRC_W-1:0]           wack_source_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [OP_W-1:0] OP_ACCESS_ACK_DATA = OP_W'(1);
  localparam logic [CW-1:0]   DEPTH_C            = CW'(DEPTH);

  logic [OP_W-1:0]   op_mem   [DEPTH];
  logic [SRC_W-1:0]  src_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count, credits;
  logic [OP_W-1:0]   last_op;
  logic [SRC_W-1:0]  last_src;
  logic [DATA_W-1:0] last_data;

  logic              empty, full, head_is_refill, pop, push, drop;
  logic [OP_W-1:0]   head_op;
  logic [SRC_W-1:0]  head_src;
  logic [DATA_W-1:0] head_data;

  assign empty          = (count == '0);
  assign full           = (count == DEPTH_C);
  assign head_op        = op_mem[rd_ptr];
  assign head_src       = src_mem[rd_ptr];
  assign head_data      = data_mem[rd_ptr];
  assign head_is_refill = (head_op == OP_ACCESS_ACK_DATA);

  // Handshake: an entry leaves only on valid & ready of the port its opcode selects; a ready
  // on the other port is ignored, so a stalled head holds back everything queued behind it.
  assign refill_valid_o = !empty && head_is_refill;
  assign wack_valid_o   = !empty && !head_is_refill;
  assign pop            = (refill_valid_o && refill_ready_i) || (wack_valid_o && wack_ready_i);
  // A pop frees the head slot this edge, so a push into a full FIFO is legal alongside it.
  assign push           = in_valid_i && (!full || pop);
  assign drop           = in_valid_i && full && !pop;

  assign refill_source_o = empty ? last_src  : head_src;
  assign refill_data_o   = empty ? last_data : head_data;
  assign wack_opcode_o   = empty ? last_op   : head_op;
  assign wack_source_o   = empty ? last_src  : head_src;
  assign credits_o       = credits;
  assign credit_avail_o  = (credits != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr]   <= in_opcode_i;
      src_mem[wr_ptr]  <= in_source_i;
      data_mem[wr_ptr] <= in_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      last_op    <= '0;
      last_src   <= '0;
      last_data  <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_op   <= head_op;
        last_src  <= head_src;
        last_data <= head_data;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) overflow_o <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits     <= DEPTH_C;
      underflow_o <= 1'b0;
    end else begin
      if (a_fire_i && credits == '0) underflow_o <= 1'b1;
      case ({a_fire_i, pop})
        2'b10:   if (credits != '0) credits <= credits - 1'b1;
        2'b01:   if (credits != DEPTH_C) credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end

endmodule

// File: tb/tb_sinkd_resp_sched.sv
// Bench for sinkd_resp_sched: directed scenarios plus random traffic, all outputs compared
// each cycle against a queue-based model of the response buffer and credit pool.
module tb_sinkd_resp_sched;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid_i = 1'b0;
  logic [2:0]  in_opcode_i = '0;
  logic [7:0]  in_source_i = '0;
  logic [63:0] in_data_i = '0;
  logic        a_fire_i = 1'b0;
  logic        credit_avail_o;
  logic [2:0]  credits_o;
  logic        refill_valid_o, refill_ready_i = 1'b0;
  logic [7:0]  refill_source_o;
  logic [63:0] refill_data_o;
  logic        wack_valid_o, wack_ready_i = 1'b0;
  logic [2:0]  wack_opcode_o;
  logic [7:0]  wack_source_o;
  logic        overflow_o, underflow_o;

  sinkd_resp_sched #(.DEPTH(DEPTH), .OP_W(3), .SRC_W(8), .DATA_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid_i), .in_opcode_i(in_opcode_i), .in_source_i(in_source_i),
    .in_data_i(in_data_i), .a_fire_i(a_fire_i),
    .credit_avail_o(credit_avail_o), .credits_o(credits_o),
    .refill_valid_o(refill_valid_o), .refill_ready_i(refill_ready_i),
    .refill_source_o(refill_source_o), .refill_data_o(refill_data_o),
    .wack_valid_o(wack_valid_o), .wack_ready_i(wack_ready_i),
    .wack_opcode_o(wack_opcode_o), .wack_source_o(wack_source_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  // Model state: entries packed as {opcode, source, data}.
  logic [74:0] exp_q[$];
  logic [74:0] m_last;
  int          m_credits;
  bit          m_overflow, m_underflow;
  int          outstanding;
  int          checks = 0;
  int          errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [74:0] h;
    bit          ne;
    ne = (exp_q.size() > 0);
    h  = ne ? exp_q[0] : m_last;
    check_eq("credits", 64'(credits_o), 64'(m_credits));
    check_eq("credit_avail", 64'(credit_avail_o), 64'(m_credits != 0));
    check_eq("refill_valid", 64'(refill_valid_o), 64'(ne && h[74:72] == 3'd1));
    check_eq("wack_valid", 64'(wack_valid_o), 64'(ne && h[74:72] != 3'd1));
    check_eq("refill_source", 64'(refill_source_o), 64'(h[71:64]));
    check_eq("refill_data", refill_data_o, h[63:0]);
    check_eq("wack_opcode", 64'(wack_opcode_o), 64'(h[74:72]));
    check_eq("wack_source", 64'(wack_source_o), 64'(h[71:64]));
    check_eq("overflow", 64'(overflow_o), 64'(m_overflow));
    check_eq("underflow", 64'(underflow_o), 64'(m_underflow));
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_last      = '0;
    m_credits   = DEPTH;
    m_overflow  = 0;
    m_underflow = 0;
    outstanding = 0;
  endtask

  // One clock: drive at negedge, check, advance the model, return at the posedge.
  task automatic cycle(input logic v, input logic [2:0] op, input logic [7:0] src,
                       input logic [63:0] d, input logic fire, input logic rr, input logic wr);
    bit pop, drop;
    @(negedge clk);
    in_valid_i = v; in_opcode_i = op; in_source_i = src; in_data_i = d;
    a_fire_i = fire; refill_ready_i = rr; wack_ready_i = wr;
    #1 check_outputs();
    pop = 0;
    if (exp_q.size() > 0) pop = (exp_q[0][74:72] == 3'd1) ? rr : wr;
    drop = v && exp_q.size() == DEPTH && !pop;
    if (fire && m_credits == 0) m_underflow = 1;
    if (fire && !pop) begin
      if (m_credits > 0) m_credits--;
    end else if (pop && !fire) begin
      if (m_credits < DEPTH) m_credits++;
    end
    if (drop) m_overflow = 1;
    if (pop) m_last = exp_q.pop_front();
    if (v && !drop) exp_q.push_back({op, src, d});
    @(posedge clk);
  endtask

  task automatic idle(input int n, input logic rr, input logic wr);
    for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 8'd0, 64'd0, 1'b0, rr, wr);
  endtask

  task automatic push_one(input logic [2:0] op, input logic [7:0] src, input logic [63:0] d);
    cycle(1'b1, op, src, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid_i = 0; a_fire_i = 0; refill_ready_i = 0; wack_ready_i = 0;
    #1 model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Reset then idle.
    idle(2, 1'b0, 1'b0);

    // Spend all credits, then a refill response is taken the cycle after its push.
    for (int i = 0; i < 4; i++) cycle(1'b0, 3'd0, 8'd0, 64'd0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 3'd1, 8'h12, 64'hA5A5, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1, 1'b0);

    // Write-ack head blocks a refill entry behind it.
    cycle(1'b1, 3'd0, 8'd3, 64'h33, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 3'd1, 8'd4, 64'h44, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b1, 1'b0);
    idle(1, 1'b1, 1'b1);
    idle(2, 1'b0, 1'b0);
    idle(1, 1'b1, 1'b0);

    // Fill, push+pop while full, then overflow.
    do_reset();
    push_one(3'd0, 8'h20, 64'h100);
    push_one(3'd1, 8'h21, 64'h101);
    push_one(3'd2, 8'h22, 64'h102);
    push_one(3'd1, 8'h23, 64'h103);
    cycle(1'b1, 3'd4, 8'h24, 64'h104, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b0, 1'b0);
    push_one(3'd0, 8'h25, 64'h105);
    idle(6, 1'b1, 1'b1);

    // Fire and pop together at credits=2, then underflow at credits=0.
    do_reset();
    cycle(1'b0, 3'd0, 8'd0, 64'd0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 3'd0, 8'h30, 64'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 3'd0, 8'd0, 64'd0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 3'd0, 8'd0, 64'd0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 3'd0, 8'd0, 64'd0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 3'd0, 8'd0, 64'd0, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0, 1'b0);

    // Reset mid-operation with three entries and one credit left.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0, 8'd0, 64'd0, 1'b1, 1'b0, 1'b0);
    push_one(3'd1, 8'h40, 64'h40);
    push_one(3'd0, 8'h41, 64'h41);
    push_one(3'd1, 8'h42, 64'h42);
    do_reset();
    push_one(3'd1, 8'h50, 64'hBEEF);
    idle(2, 1'b1, 1'b1);

    // Legal random traffic: responses only for outstanding requests.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      logic v, f;
      v = (outstanding > 0) && ($urandom_range(0, 1) == 1);
      f = (m_credits > 0) && ($urandom_range(0, 1) == 1);
      cycle(v, 3'($urandom_range(0, 3)), 8'($urandom), {$urandom, $urandom}, f,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      outstanding = outstanding + int'(f) - int'(v);
      #1 check_eq("invariant", 64'(int'(credits_o) + outstanding + exp_q.size()), 64'(DEPTH));
    end

    // Unconstrained random traffic, exercising the error flags and periodic reset.
    for (int i = 0; i < 300; i++) begin
      if (i % 100 == 0) do_reset();
      cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
            {$urandom, $urandom}, 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    idle(1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sinkd_resp_sched.md
Name: sinkd_resp_sched

Overview:
- Credit-based scheduler and buffer sitting between the L2 D-channel receive stage and the L2 consumers.
- The receive stage always accepts memory responses and cannot stall memory. This block buffers each registered response in a FIFO and steers it by opcode: AccessAckData goes to the refill port, everything else goes to the write-ack port.
- It also limits outstanding A-channel requests with a credit counter, so the FIFO can never overflow.

Parameters:
- DEPTH, 4, FIFO entries and initial credit count; power of two, 2..16.
- OP_W, 3, opcode width.
- SRC_W, 8, source ID width.
- DATA_W, 64, response data width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid_i  input  1  registered response valid from the receive stage; no backpressure.
- in_opcode_i  input  OP_W  response opcode.
- in_source_i  input  SRC_W  response source ID.
- in_data_i  input  DATA_W  response data.
- a_fire_i  input  1  one A-channel request issued to memory this cycle.
- credit_avail_o  output  1  at least one credit free; A-channel issue is gated by this.
- credits_o  output  $clog2(DEPTH)+1  current free credit count.
- refill_valid_o  output  1  head entry is AccessAckData.
- refill_ready_i  input  1  refill consumer accepts.
- refill_source_o  output  SRC_W  head source.
- refill_data_o  output  DATA_W  head data.
- wack_valid_o  output  1  head entry is a non-data response.
- wack_ready_i  input  1  write-ack consumer accepts.
- wack_opcode_o  output  OP_W  head opcode.
- wack_source_o  output  SRC_W  head source.
- overflow_o  output  1  sticky error: push while full and no pop.
- underflow_o  output  1  sticky error: a_fire_i while credits==0.

Behaviour:
- Reset (asynchronous, immediate on rst_n low):
  - FIFO empty, rd/wr pointers 0, credits=DEPTH.
  - credit_avail_o=1, refill_valid_o=0, wack_valid_o=0, overflow_o=0, underflow_o=0.
  - All data, source and opcode outputs 0.
  - Reset mid-operation discards every buffered entry and restores full credits.
- FIFO storage:
  - Push when in_valid_i=1.
  - Storage is registered with no bypass. A push at edge t is visible at the head after edge t, so a consumer can first accept it in cycle t+1.
  - Pointers wrap modulo DEPTH. Full/empty are tracked with a count register ranging 0..DEPTH.
- Head steering, strictly in-order with no reordering:
  - Opcode 3'd1 (AccessAckData): refill_valid_o=1, wack_valid_o=0.
  - Any other opcode (AccessAck=0, HintAck, etc.): wack_valid_o=1, refill_valid_o=0.
  - Both valids are 0 when the FIFO is empty. The two valids are never 1 together.
- Pop:
  - Pop when (refill_valid_o & refill_ready_i) | (wack_valid_o & wack_ready_i).
  - A ready on the non-selected port is ignored, so a stalled head blocks all entries behind it.
- Head outputs:
  - Driven from the head entry whenever the FIFO is non-empty.
  - Hold the last popped values when empty; valid is 0 in that case.
- Simultaneous push and pop:
  - Count is unchanged. This is legal even when count==DEPTH, and overflow_o is not set.
- Push while count==DEPTH with no pop:
  - Entry dropped, overflow_o set and held until reset.
- Credits:
  - a_fire_i decrements; a pop increments; both in the same cycle leave credits unchanged.
  - a_fire_i while credits==0: count stays 0 and underflow_o is set (sticky).
  - A pop never raises credits above DEPTH.
  - credit_avail_o = (credits_o != 0), combinational from the register.
- Invariant: credits + outstanding + count == DEPTH, where outstanding = A-channel requests issued but not yet responded. This invariant guarantees no overflow under legal use.

Test Plan:
- Reset then idle:
  - Required: credits_o=4, credit_avail_o=1, both valids 0, both error flags 0.
- 4× a_fire_i, then in_valid_i with opcode 1, source 0x12, data 0xA5A5, refill_ready_i=1:
  - Credits go 4→0 and credit_avail_o=0.
  - refill_valid_o=1 with source 0x12, data 0xA5A5 one cycle after the push.
  - Pop occurs that cycle and credits_o returns to 1.
- Push opcode 0 (src 3), then opcode 1 (src 4), with wack_ready_i=0 and refill_ready_i=1 for 3 cycles:
  - refill_valid_o stays 0 and wack_valid_o=1 with src 3; the head blocks the entry behind it.
  - Raise wack_ready_i: src 3 pops, then refill_valid_o=1 with src 4 on the next cycle.
- Fill FIFO to 4 entries with both readies low, then push and pop in the same cycle:
  - Count stays 4, overflow_o=0, and the new entry lands last in order.
  - A further push with no pop: overflow_o=1 and stays 1 until rst_n pulse.
- a_fire_i and a pop in the same cycle with credits=2:
  - Credits remain 2.
  - a_fire_i at credits=0: credits stay 0 and underflow_o=1.
- Assert rst_n low with 3 entries buffered and credits=1:
  - Immediately: valids 0, credits_o=4, flags 0.
  - After release, first push appears at the head one cycle later.
